zxuno_uart_fifo: RTL and testbench
==================================

ZXUNO_UART_FIFO -- requirements
Module: zxuno_uart_fifo

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- UARTDATA, 8'hC6, data register address.
- UARTSTAT, 8'hC7, status register address.
- DEPTH_LOG2, 4, log2 of the depth of each FIFO (RX and TX); range 2..5.
- RTS_MARGIN, 2, free RX slots at or below which uart_rts asserts.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_bus, in, 1, the single clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- zxuno_addr, in, 8, register address.
- zxuno_regrd, in, 1, read strobe, level, held one or more cycles.
- zxuno_regwr, in, 1, write strobe, level, held one or more cycles.
- din, in, 8, write data.
- dout, out, 8, read data.
- oe_n, out, 1, read-data enable, active-low.
- tx_data, out, 8, byte to the serializer.
- tx_start, out, 1, serializer start request.
- tx_busy, in, 1, serializer busy.
- rx_data, in, 8, received byte.
- rx_valid, in, 1, one-cycle received-byte strobe.
- uart_rts, out, 1, 1 = ask the far end to pause.

Function
REQ-003 rdsel = (zxuno_addr==UARTDATA & zxuno_regrd); stsel = (zxuno_addr==UARTSTAT & zxuno_regrd); both combinational.
REQ-004 oe_n SHALL be 0 exactly when rdsel or stsel is true, otherwise 1; dout SHALL be 8'hFF when oe_n=1.
REQ-005 On rdsel, dout SHALL equal the RX FIFO head; on an empty RX FIFO it SHALL equal 8'h00.
REQ-006 On stsel, dout SHALL be {rx_nonempty, tx_full, rx_ovf, rx_level[4:0]}; rx_level SHALL saturate at 31.
REQ-007 RX pop SHALL occur once per read access, in the cycle after rdsel falls (registered edge detect), only if RX is non-empty; dout SHALL be stable for the whole access.
REQ-008 TX push of din SHALL occur once per write access to UARTDATA, in the first cycle of the strobe (rising edge); a push while TX is full SHALL be dropped silently.
REQ-009 rx_valid=1 SHALL push rx_data; it SHALL be accepted if RX is not full, or if an RX pop occurs in the same cycle; otherwise the byte is dropped and rx_ovf is set to 1.
REQ-010 rx_ovf SHALL clear in the cycle after a stsel access ends, unless rx_valid sets it in that same cycle (set wins).
REQ-011 Simultaneous push and pop on one FIFO SHALL leave its count unchanged; pointers SHALL wrap modulo 2^DEPTH_LOG2; count width SHALL be DEPTH_LOG2+1.
REQ-012 TX drain states:
- IDLE: when TX is non-empty, latch the head into tx_data, assert tx_start and go to REQ.
- REQ: when tx_busy=1, deassert tx_start, pop TX and go to WAIT.
- WAIT: when tx_busy=0, go to IDLE.
REQ-013 tx_data SHALL hold its value from the IDLE exit until the next IDLE exit; the minimum gap between bytes is one cycle after tx_busy falls.
REQ-014 uart_rts SHALL be registered, equal to (free RX slots <= RTS_MARGIN), and update one cycle after any count change.

Reset
REQ-015 While rst_n=0: FIFOs empty, pointers 0, rx_ovf=0, TX state IDLE, tx_start=0, tx_data=8'h00, uart_rts=0, edge-detect registers 0.
REQ-016 Reset in the middle of a REQ or WAIT state SHALL abandon the in-flight byte; no pop and no retry follow.

Configuration
REQ-017 Macro ZXUNO_UART_FIFO_FLUSH_EN:
- Defined: a write access to UARTSTAT with din[0]=1 empties the RX FIFO and clears rx_ovf, and din[1]=1 empties the TX FIFO (no effect on a byte already in REQ or WAIT), one cycle after the strobe rises; a flush overrides a same-cycle push.
- Undefined: writes to UARTSTAT are ignored.

Verification
REQ-018 After reset, stsel -> dout=8'h00, oe_n=0, uart_rts=0, tx_start=0.
REQ-019 Write 8'h41, 8'h42 with tx_busy echoing tx_start after 3 cycles -> tx_data 8'h41 then 8'h42, one tx_start per byte, TX empty afterwards.
REQ-020 Push 16 rx_valid bytes 8'h00..8'h0F (DEPTH_LOG2=4) -> uart_rts=1 after the 14th; 17th byte 8'hAA dropped; status=8'hB0; a second status read -> 8'h90.
REQ-021 rdsel held 5 cycles -> dout constant at 8'h00, exactly one pop; rx_valid in the same cycle as the pop while full -> byte accepted, count stays 16.
REQ-022 rst_n low during REQ with 3 bytes queued -> tx_start=0 immediately; TX empty after release.
REQ-023 With ZXUNO_UART_FIFO_FLUSH_EN defined, write 8'h03 to UARTSTAT -> both FIFOs empty, status=8'h00; undefined -> FIFO counts unchanged.

Source files
------------

// File: rtl/zxuno_uart_fifo_if.sv
// ZX-Uno register-bus port bundle for the UART FIFO: address, strobes,
// write data and the read-data return path.
interface zxuno_uart_fifo_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
                  input  dout, oe_n);
  modport slave  (input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
                  output dout, oe_n);
endinterface

// File: rtl/zxuno_uart_fifo.sv
// UART byte buffering for the ZX-Uno register bus: RX/TX FIFOs, status register,
// TX drain FSM and RTS flow control. Optional FIFO flush: ZXUNO_UART_FIFO_FLUSH_EN.
//
// state  | meaning
// S_IDLE | TX FIFO empty or about to offer its head byte
// S_REQ  | tx_start asserted, waiting for the serializer to go busy
// S_WAIT | byte taken, waiting for the serializer to finish
module zxuno_uart_fifo #(
  parameter logic [7:0] UARTDATA   = 8'hC6,
  parameter logic [7:0] UARTSTAT   = 8'hC7,
  parameter int         DEPTH_LOG2 = 4,
  parameter int         RTS_MARGIN = 2
) (
  input  logic                    clk_bus,
  input  logic                    rst_n,
  zxuno_uart_fifo_if.slave        bus,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    uart_rts
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} tx_state_e;

  logic                  rdsel, stsel, wr_rise, wrdata_rise;
  logic                  rd_q, st_q, wr_q;
  logic                  rx_acc, rx_push, rx_pop, tx_push, tx_pop;
  logic                  rx_flush, tx_flush;
  logic                  rx_empty, rx_full, tx_empty, tx_full;
  logic [DEPTH_LOG2-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [7:0]            rx_mem_q [DEPTH];
  logic [7:0]            tx_mem_q [DEPTH];
  logic                  rx_ovf_q, rx_ovf_d, rts_q;
  logic                  held_q, held_d;
  tx_state_e             state_q, state_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [5:0]            rx_lvl6;
  logic [4:0]            rx_level;

  assign rdsel       = (bus.zxuno_addr == UARTDATA) && bus.zxuno_regrd;
  assign stsel       = (bus.zxuno_addr == UARTSTAT) && bus.zxuno_regrd;
  assign wr_rise     = bus.zxuno_regwr && !wr_q;
  assign wrdata_rise = wr_rise && (bus.zxuno_addr == UARTDATA);

`ifdef ZXUNO_UART_FIFO_FLUSH_EN
  logic wrstat_rise;
  assign wrstat_rise = wr_rise && (bus.zxuno_addr == UARTSTAT);
  assign rx_flush    = wrstat_rise && bus.din[0];
  assign tx_flush    = wrstat_rise && bus.din[1];
`else
  assign rx_flush    = 1'b0;
  assign tx_flush    = 1'b0;
`endif

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(DEPTH));

  // Pop after the read access ends so dout cannot change mid-access.
  assign rx_pop  = rd_q && !rdsel && !rx_empty && !rx_flush;
  assign rx_acc  = rx_valid && (!rx_full || rx_pop);
  assign rx_push = rx_acc && !rx_flush;
  assign tx_push = wrdata_rise && !tx_full && !tx_flush;

  assign rx_lvl6  = 6'(rx_cnt_q);
  assign rx_level = (rx_lvl6 > 6'd31) ? 5'd31 : rx_lvl6[4:0];

  always_comb begin
    bus.oe_n = !(rdsel || stsel);
    bus.dout = 8'hFF;
    if (rdsel)
      bus.dout = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
    else if (stsel)
      bus.dout = {!rx_empty, tx_full, rx_ovf_q, rx_level};
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_flush)
      rx_cnt_d = '0;
    else if (rx_push && !rx_pop)
      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (!rx_push && rx_pop)
      rx_cnt_d = rx_cnt_q - 1'b1;

    tx_cnt_d = tx_cnt_q;
    if (tx_flush)
      tx_cnt_d = '0;
    else if (tx_push && !tx_pop)
      tx_cnt_d = tx_cnt_q + 1'b1;
    else if (!tx_push && tx_pop)
      tx_cnt_d = tx_cnt_q - 1'b1;

    // A new overflow wins over the clear that follows a status read.
    rx_ovf_d = rx_ovf_q;
    if (st_q && !stsel)
      rx_ovf_d = 1'b0;
    if (rx_flush)
      rx_ovf_d = 1'b0;
    else if (rx_valid && !rx_acc)
      rx_ovf_d = 1'b1;
  end

  // held_q marks that the in-flight byte still occupies the TX head, so a
  // flush in REQ/WAIT cannot make the later pop consume a newer byte.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    held_d    = held_q;
    tx_start  = 1'b0;
    tx_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_data_d = tx_mem_q[tx_rp_q];
          held_d    = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        tx_start = 1'b1;
        if (tx_busy) begin
          tx_pop  = held_q && !tx_flush;
          held_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!tx_busy)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tx_flush)
      held_d = 1'b0;
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= 1'b0;
      st_q      <= 1'b0;
      wr_q      <= 1'b0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      rts_q     <= 1'b0;
      held_q    <= 1'b0;
      state_q   <= S_IDLE;
      tx_data_q <= 8'h00;
    end else begin
      rd_q      <= rdsel;
      st_q      <= stsel;
      wr_q      <= bus.zxuno_regwr;
      rx_cnt_q  <= rx_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      rts_q     <= (int'(rx_cnt_q) + RTS_MARGIN) >= DEPTH;
      held_q    <= held_d;
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      if (rx_flush) begin
        rx_wp_q <= '0;
        rx_rp_q <= '0;
      end else begin
        if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      end
      if (tx_flush) begin
        tx_wp_q <= '0;
        tx_rp_q <= '0;
      end else begin
        if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_bus) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.din;
  end

  assign tx_data  = tx_data_q;
  assign uart_rts = rts_q;
endmodule

// File: tb/tb_zxuno_uart_fifo.sv
// Bench for zxuno_uart_fifo: queue-based reference model of both FIFOs, a
// serializer model answering tx_start, randomized RX/TX traffic.
module tb_zxuno_uart_fifo;
  localparam logic [7:0] UARTDATA = 8'hC6;
  localparam logic [7:0] UARTSTAT = 8'hC7;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic       clk_bus = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       uart_rts;

  always #5 clk_bus = ~clk_bus;

  zxuno_uart_fifo_if bus();

  zxuno_uart_fifo dut (
    .clk_bus (clk_bus),
    .rst_n   (rst_n),
    .bus     (bus),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .tx_busy (tx_busy),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .uart_rts(uart_rts)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rxq[$];
  bit         m_ovf = 1'b0;
  logic [7:0] got[$];
  bit         ser_en = 1'b1;

  function automatic logic [7:0] exp_status(input bit txf);
    return {(rxq.size() > 0), txf, m_ovf, 5'(rxq.size())};
  endfunction

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  // Serializer model: goes busy 3 cycles after tx_start, stays busy 4 cycles.
  initial begin : serializer
    int   d;
    int   b;
    logic prev;
    tx_busy = 1'b0;
    d = 0; b = 0; prev = 1'b0;
    forever begin
      @(posedge clk_bus);
      #2;
      if (!rst_n) begin
        tx_busy = 1'b0; d = 0; prev = 1'b0;
      end else begin
        if (tx_start && !prev) got.push_back(tx_data);
        prev = tx_start;
        if (tx_busy) begin
          if (b == 0) tx_busy = 1'b0;
          else b--;
        end else if (tx_start && ser_en) begin
          d++;
          if (d >= 3) begin tx_busy = 1'b1; b = 3; d = 0; end
        end else begin
          d = 0;
        end
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    tick();
    bus.zxuno_addr  = a;
    bus.din         = d;
    bus.zxuno_regwr = 1'b1;
    tick();
    bus.zxuno_regwr = 1'b0;
    bus.zxuno_addr  = 8'h00;
  endtask

  // Returns while still in the cycle right after the strobe drops.
  task automatic bus_read(input logic [7:0] a, input int n, output logic [7:0] v,
                          output bit stable, output bit oe_ok);
    tick();
    bus.zxuno_addr  = a;
    bus.zxuno_regrd = 1'b1;
    #1;
    v      = bus.dout;
    stable = 1'b1;
    oe_ok  = (bus.oe_n === 1'b0);
    for (int i = 1; i < n; i++) begin
      tick();
      if (bus.dout !== v) stable = 1'b0;
      if (bus.oe_n !== 1'b0) oe_ok = 1'b0;
    end
    tick();
    bus.zxuno_regrd = 1'b0;
    bus.zxuno_addr  = 8'h00;
  endtask

  task automatic rx_push(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v; bit st; bit oe;
    rst_n = 1'b0;
    bus.zxuno_addr = 8'h00; bus.zxuno_regrd = 1'b0; bus.zxuno_regwr = 1'b0; bus.din = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx_start !== 1'b0 || uart_rts !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: tx_start=%b rts=%b tx_data=%h, want 0 0 00", tx_start, uart_rts, tx_data);
    end
    checks++;
    if (bus.oe_n !== 1'b1 || bus.dout !== 8'hFF) begin
      errors++; $display("FAIL idle_bus: oe_n=%b dout=%h, want 1 ff", bus.oe_n, bus.dout);
    end
    rst_n = 1'b1;
    tick();
    bus_read(UARTSTAT, 1, v, st, oe);
    checks++;
    if (v !== 8'h00 || !oe || uart_rts !== 1'b0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL reset_status: dout=%h oe=%b rts=%b start=%b, want 00 1 0 0", v, oe, uart_rts, tx_start);
    end
  endtask

  task automatic test_tx_basic();
    got.delete();
    ser_en = 1'b1;
    bus_write(UARTDATA, 8'h41);
    bus_write(UARTDATA, 8'h42);
    for (int c = 0; c < 300 && got.size() < 2; c++) tick();
    repeat (30) tick();
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL tx_basic_count: got %0d starts, want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 8'h41 || got[1] !== 8'h42) begin
        errors++; $display("FAIL tx_basic_data: got %h %h, want 41 42", got[0], got[1]);
      end
    end
  endtask

  task automatic test_tx_random();
    logic [7:0] exp[$];
    got.delete();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp.push_back(b);
      bus_write(UARTDATA, b);
    end
    for (int c = 0; c < 1000 && got.size() < exp.size(); c++) tick();
    repeat (30) tick();
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL tx_random_count: got %0d, want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++; $display("FAIL tx_random_byte%0d: got %h, want %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp[$];
    logic [7:0] v; bit st; bit oe;
    got.delete();
    ser_en = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i < DEPTH) exp.push_back(b);
      bus_write(UARTDATA, b);
    end
    bus_read(UARTSTAT, 1, v, st, oe);
    checks++;
    if (v !== exp_status(1'b1)) begin
      errors++; $display("FAIL tx_full_status: dout=%h, want %h", v, exp_status(1'b1));
    end
    ser_en = 1'b1;
    for (int c = 0; c < 2000 && got.size() < exp.size(); c++) tick();
    repeat (30) tick();
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL tx_full_count: got %0d, want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++; $display("FAIL tx_full_byte%0d: got %h, want %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_rx_fill();
    logic [7:0] v; bit st; bit oe;
    for (int i = 0; i < DEPTH; i++) begin
      rx_push(8'(i));
      tick();
      checks++;
      if (uart_rts !== ((DEPTH - rxq.size()) <= MARGIN)) begin
        errors++; $display("FAIL rx_fill_rts%0d: rts=%b, want %b", i, uart_rts, (DEPTH - rxq.size()) <= MARGIN);
      end
    end
    rx_push(8'hAA);
    bus_read(UARTSTAT, 2, v, st, oe);
    checks++;
    if (v !== exp_status(1'b0) || v !== 8'hB0 || !st || !oe) begin
      errors++; $display("FAIL rx_fill_status1: dout=%h stable=%b, want b0", v, st);
    end
    m_ovf = 1'b0;
    bus_read(UARTSTAT, 1, v, st, oe);
    checks++;
    if (v !== exp_status(1'b0) || v !== 8'h90) begin
      errors++; $display("FAIL rx_fill_status2: dout=%h, want 90", v);
    end
  endtask

  task automatic test_read_hold();
    logic [7:0] v; logic [7:0] e; bit st; bit oe;
    e = rxq[0];
    bus_read(UARTDATA, 5, v, st, oe);
    checks++;
    if (v !== e || !st || !oe) begin
      errors++; $display("FAIL read_hold: dout=%h stable=%b oe=%b, want %h 1 1", v, st, oe, e);
    end
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    void'(rxq.pop_front());
    rxq.push_back(8'h55);
    bus_read(UARTSTAT, 1, v, st, oe);
    checks++;
    if (v !== exp_status(1'b0) || v !== 8'h90) begin
      errors++; $display("FAIL pop_push_status: dout=%h, want 90", v);
    end
    e = rxq[0];
    bus_read(UARTDATA, 1, v, st, oe);
    void'(rxq.pop_front());
    checks++;
    if (v !== e) begin
      errors++; $display("FAIL read_hold_next: dout=%h, want %h", v, e);
    end
  endtask

  task automatic test_rx_random();
    logic [7:0] v; logic [7:0] e; bit st; bit oe;
    for (int s = 0; s < 90; s++) begin
      case ($urandom_range(0, 3))
        0, 1: rx_push(8'($urandom));
        2: begin
          e = (rxq.size() > 0) ? rxq[0] : 8'h00;
          bus_read(UARTDATA, int'($urandom_range(1, 4)), v, st, oe);
          if (rxq.size() > 0) void'(rxq.pop_front());
          checks++;
          if (v !== e || !st || !oe) begin
            errors++; $display("FAIL rx_random_data step%0d: dout=%h stable=%b, want %h", s, v, st, e);
          end
        end
        default: begin
          tick(); tick();
          checks++;
          if (uart_rts !== ((DEPTH - rxq.size()) <= MARGIN)) begin
            errors++; $display("FAIL rx_random_rts step%0d: rts=%b, level %0d", s, uart_rts, rxq.size());
          end
          e = exp_status(1'b0);
          bus_read(UARTSTAT, 1, v, st, oe);
          m_ovf = 1'b0;
          checks++;
          if (v !== e) begin
            errors++; $display("FAIL rx_random_status step%0d: dout=%h, want %h", s, v, e);
          end
        end
      endcase
    end
  endtask

  task automatic test_flush();
    logic [7:0] v; logic [7:0] e; bit st; bit oe;
    logic [7:0] txb[3];
    logic [7:0] rxb[3];
    e = exp_status(1'b0);
    bus_read(UARTSTAT, 1, v, st, oe);
    m_ovf = 1'b0;
    checks++;
    if (v !== e) begin
      errors++; $display("FAIL flush_pre_status: dout=%h, want %h", v, e);
    end
    while (rxq.size() > 0) begin
      e = rxq.pop_front();
      bus_read(UARTDATA, 1, v, st, oe);
      checks++;
      if (v !== e) begin
        errors++; $display("FAIL flush_drain: dout=%h, want %h", v, e);
      end
    end
    ser_en = 1'b0;
    got.delete();
    for (int i = 0; i < 3; i++) begin
      rxb[i] = 8'($urandom);
      rx_push(rxb[i]);
    end
    for (int i = 0; i < 3; i++) begin
      txb[i] = 8'($urandom);
      bus_write(UARTDATA, txb[i]);
    end
    bus_write(UARTSTAT, 8'h03);
`ifdef ZXUNO_UART_FIFO_FLUSH_EN
    rxq.delete();
    m_ovf = 1'b0;
`endif
    e = exp_status(1'b0);
    bus_read(UARTSTAT, 1, v, st, oe);
    checks++;
    if (v !== e) begin
      errors++; $display("FAIL flush_status: dout=%h, want %h", v, e);
    end
    ser_en = 1'b1;
    repeat (120) tick();
`ifdef ZXUNO_UART_FIFO_FLUSH_EN
    checks++;
    if (got.size() != 1 || got[0] !== txb[0]) begin
      errors++; $display("FAIL flush_tx: got %0d bytes, want 1 (in-flight %h)", got.size(), txb[0]);
    end
`else
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL noflush_tx_count: got %0d, want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== txb[i]) begin
          errors++; $display("FAIL noflush_tx_byte%0d: got %h, want %h", i, got[i], txb[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      e = rxq.pop_front();
      bus_read(UARTDATA, 1, v, st, oe);
      checks++;
      if (v !== e || v !== rxb[i]) begin
        errors++; $display("FAIL noflush_rx_byte%0d: dout=%h, want %h", i, v, e);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] v; bit st; bit oe;
    ser_en = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(UARTDATA, 8'(8'h60 + i));
    for (int c = 0; c < 20 && tx_start !== 1'b1; c++) tick();
    checks++;
    if (tx_start !== 1'b1) begin
      errors++; $display("FAIL reset_mid_req: tx_start=%b, want 1", tx_start);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_mid_async: tx_start=%b tx_data=%h, want 0 00", tx_start, tx_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    rxq.delete();
    m_ovf = 1'b0;
    got.delete();
    ser_en = 1'b1;
    repeat (40) tick();
    checks++;
    if (got.size() != 0) begin
      errors++; $display("FAIL reset_mid_tx_empty: %0d bytes sent after reset, want 0", got.size());
    end
    bus_read(UARTSTAT, 1, v, st, oe);
    checks++;
    if (v !== 8'h00 || uart_rts !== 1'b0) begin
      errors++; $display("FAIL reset_mid_status: dout=%h rts=%b, want 00 0", v, uart_rts);
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_random();
    test_tx_full();
    test_rx_fill();
    test_read_hold();
    test_rx_random();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
